reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the core's single-write, two-read register file.
- Provides NUM_READ asynchronous read ports and one synchronous write port, with same-cycle write-to-read bypass.
- Holds a per-register busy scoreboard for hazard detection in the decode stage.
- After reset, runs a sequential clear sweep so that every register reads zero before `ready` asserts.

Parameters:
- WORD_SIZE, 32: data width of each register, in bits.
- NUM_REGS, 32: number of architectural registers; power of two, at least 2.
- NUM_READ, 2: number of read ports; from 1 to 4.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero and never marked busy.
- Derived: ADDR_W = $clog2(NUM_REGS).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  out  1  high once the clear sweep has completed; the block accepts writes and issues only while high.
- rd_addr  in  NUM_READ*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_READ*WORD_SIZE  read data; port i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- rd_busy  out  NUM_READ  scoreboard busy flag for each read address.
- wr_en  in  1  write strobe (retire).
- wr_addr  in  ADDR_W  destination register of the write.
- wr_data  in  WORD_SIZE  data to write.
- issue_en  in  1  marks issue_rd as having an in-flight producer.
- issue_rd  in  ADDR_W  destination register of the instruction being issued.

Behaviour:
- State machine has two states, CLEAR and RUN.
- Async reset (reset=1, at any time, including mid-sweep or during RUN):
  - state=CLEAR, clr_idx=0, all busy bits=0, ready=0.
  - Register contents are not reset directly; the sweep clears them.
- CLEAR state:
  - Each cycle: registers[clr_idx] <= 0, clr_idx <= clr_idx+1.
  - When clr_idx == NUM_REGS-1, the last register is written and state goes to RUN.
  - ready rises on the cycle after that last write, i.e. NUM_REGS clock edges after reset deasserts.
  - wr_en and issue_en are ignored.
  - rd_data=0 and rd_busy=0 on all ports.
- RUN state:
  - ready=1.
  - The block stays in RUN until the next reset.
- Write:
  - When wr_en=1, registers[wr_addr] <= wr_data on the clock edge.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (combinational, zero latency; priority in order):
  - ZERO_REG=1 and rd_addr_i=0: rd_data_i = 0.
  - Else, wr_en=1 and wr_addr == rd_addr_i: rd_data_i = wr_data (bypass).
  - Else: rd_data_i = registers[rd_addr_i].
  - Bypass is evaluated independently on every port.
- Scoreboard:
  - busy[issue_rd] is set on issue_en=1.
  - busy[wr_addr] is cleared on wr_en=1.
  - Same address in the same cycle: the set wins (the new producer supersedes the retiring one).
  - Different addresses: both the set and the clear take effect.
  - ZERO_REG=1: busy[0] is permanently 0.
- rd_busy_i:
  - = busy[rd_addr_i] & ~(wr_en & wr_addr == rd_addr_i).
  - A same-cycle retire therefore reads as not busy, consistent with the bypass.
  - Forced 0 when ZERO_REG=1 and rd_addr_i=0.
  - Forced 0 in CLEAR.
- Issuing an already-busy register keeps it busy. Clearing a non-busy register is a no-op. Neither is an error.
- Addresses are unsigned ADDR_W bits; NUM_REGS is a power of two, so every address is in range.
- No X on any output after reset: the CLEAR sweep guarantees defined register contents.

Test Plan:
1. Reset sweep, defaults: pulse reset with NUM_REGS=32, then poll ready -> ready=0 for exactly 32 cycles then 1. With rd_addr=5 and 31, rd_data=0 and rd_busy=0. A wr_en pulse to reg 3 during CLEAR is ignored: reg 3 still reads 0 afterwards.
2. Write, read and zero register: write 0xDEADBEEF to reg 7 and 0x12345678 to reg 0 -> next cycle reg 7 reads 0xDEADBEEF on both ports and reg 0 reads 0. Same-cycle read of reg 7 while writing 0xCAFEF00D returns 0xCAFEF00D via bypass.
3. Scoreboard: issue reg 9, wait 3 cycles -> rd_busy=1 for reg 9. Then wr_en to reg 9 -> rd_busy=0 in that same cycle, and it stays 0 after the edge.
4. Simultaneous set and clear on reg 12: issue reg 12 and write reg 12 in the same cycle -> the data is written, and busy[12]=1 after the edge. Issue reg 4 while retiring reg 5 -> busy[4]=1 and busy[5]=0.
5. Reset mid-operation: make regs 2 and 3 busy and write reg 2=0xAA; assert reset during CLEAR cycle 10 of a second sweep -> ready stays low for 32 cycles after deassertion, reg 2 reads 0, and all busy flags read 0.
6. Parameter sweep: NUM_REGS=16, NUM_READ=3, WORD_SIZE=64, ZERO_REG=0 -> ready rises after 16 cycles. A write of 0x0123456789ABCDEF to reg 0 is kept and readable on all 3 ports. Issuing reg 0 sets rd_busy.

Source files
------------

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp: multi-port register file with per-register busy scoreboard.
//   NUM_READ combinational read ports with same-cycle write bypass, one
//   synchronous write (retire) port and one issue port that marks a
//   destination register as having an in-flight producer.
//   After reset a sequential sweep zeroes every register; `ready` rises
//   NUM_REGS clock edges after reset deasserts.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   ready             high once the clear sweep is done; writes/issues
//                     are only honoured while high
//   rd_addr/rd_data   packed read ports, port i at [i*W +: W]
//   rd_busy           scoreboard flag per read port
//   wr_en/addr/data   retire: write data and clear busy
//   issue_en/rd       issue: set busy for the destination register
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int ZERO_REG  = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          ready,
  input  logic [NUM_READ*ADDR_W-1:0]    rd_addr,
  output logic [NUM_READ*WORD_SIZE-1:0] rd_data,
  output logic [NUM_READ-1:0]           rd_busy,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [WORD_SIZE-1:0]          wr_data,
  input  logic                          issue_en,
  input  logic [ADDR_W-1:0]             issue_rd
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam bit                HAS_ZERO = (ZERO_REG != 0);

  state_e                state_q;
  logic [ADDR_W-1:0]     clr_idx_q;
  logic                  ready_q;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [WORD_SIZE-1:0]  regs_q [NUM_REGS];

  logic                  run;
  logic                  wr_ok;

  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  // Writes to the hardwired zero register are dropped so its storage
  // keeps the value the sweep gave it.
  assign wr_ok = run && wr_en && !(HAS_ZERO && (wr_addr == '0));

  // -------------------------------------------------------------------------
  // Sweep / run control. ready is registered alongside the state so it
  // rises on the edge that performs the final clear write.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_idx_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage. No reset on the array itself: contents become defined through
  // the sweep, which shares this single write port with the retire path.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!run) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard. The set is applied after the clear so that, on a matching
  // address, the newly issued producer supersedes the retiring one.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (wr_en) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (issue_en) begin
        busy_d[issue_rd] = 1'b1;
      end
    end
    if (HAS_ZERO) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports. Priority: zero register, then write bypass, then storage.
  // A same-cycle retire also masks the busy flag so data and hazard status
  // stay consistent for the decode stage.
  // -------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit;

    assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = HAS_ZERO && (addr == '0);
    assign hit     = run && wr_en && (wr_addr == addr);

    assign rd_data[p*WORD_SIZE +: WORD_SIZE] =
        (!run || is_zero) ? '0      :
        hit               ? wr_data :
                            regs_q[addr];

    assign rd_busy[p] = run && !is_zero && busy_q[addr] && !hit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp: directed bench for reg_file_mp. Instance u_dut_a uses the
//   default parameters, u_dut_b uses NUM_REGS=16, NUM_READ=3, WORD_SIZE=64,
//   ZERO_REG=0. Inputs change 1ns after the rising edge, outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (32 x 32b, 2 read ports, zero register)
  logic        rst_a;
  logic        ready_a;
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic        wr_en_a;
  logic [4:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic        issue_en_a;
  logic [4:0]  issue_rd_a;

  // Instance B: 16 x 64b, 3 read ports, no zero register
  logic         rst_b;
  logic         ready_b;
  logic [11:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic [2:0]   rd_busy_b;
  logic         wr_en_b;
  logic [3:0]   wr_addr_b;
  logic [63:0]  wr_data_b;
  logic         issue_en_b;
  logic [3:0]   issue_rd_b;

  reg_file_mp u_dut_a (
    .clock    (clk),
    .reset    (rst_a),
    .ready    (ready_a),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a),
    .wr_en    (wr_en_a),
    .wr_addr  (wr_addr_a),
    .wr_data  (wr_data_a),
    .issue_en (issue_en_a),
    .issue_rd (issue_rd_a)
  );

  reg_file_mp #(
    .WORD_SIZE (64),
    .NUM_REGS  (16),
    .NUM_READ  (3),
    .ZERO_REG  (0)
  ) u_dut_b (
    .clock    (clk),
    .reset    (rst_b),
    .ready    (ready_b),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b),
    .wr_en    (wr_en_b),
    .wr_addr  (wr_addr_b),
    .wr_data  (wr_data_b),
    .issue_en (issue_en_b),
    .issue_rd (issue_rd_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    wr_en_a    = 1'b0;
    issue_en_a = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] p0, input logic [4:0] p1);
    rd_addr_a = {p1, p0};
  endtask

  task automatic write_a(input logic [4:0] a, input logic [31:0] d);
    wr_en_a   = 1'b1;
    wr_addr_a = a;
    wr_data_a = d;
  endtask

  task automatic issue_a(input logic [4:0] a);
    issue_en_a = 1'b1;
    issue_rd_a = a;
  endtask

  // Counts rising edges until ready is seen high, bounded.
  task automatic wait_ready(input bit sel_b, output int n);
    n = 0;
    while (((sel_b ? ready_b : ready_a) !== 1'b1) && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    rst_a = 1'b1; rst_b = 1'b1;
    rd_addr_a = '0; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    issue_en_a = 1'b0; issue_rd_a = '0;
    rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    issue_en_b = 1'b0; issue_rd_b = '0;

    // ---- 1. reset and sweep ----
    step(); step();
    @(negedge clk);
    check("rst_ready_a", ready_a, 0);
    check("rst_busy_a", rd_busy_a, 0);
    check("rst_ready_b", ready_b, 0);
    step();
    rst_a = 1'b0;
    n = 0;
    while (ready_a !== 1'b1 && n < 200) begin
      if (n == 5) begin
        rd_a(5'd5, 5'd31);
        @(negedge clk);
        check("clr_rd_data", rd_data_a, 64'h0);
        check("clr_rd_busy", rd_busy_a, 0);
      end
      if (n == 20) begin
        write_a(5'd3, 32'h0000_0055);
        issue_a(5'd3);
        rd_a(5'd3, 5'd31);
        @(negedge clk);
        check("clr_no_bypass", rd_data_a, 64'h0);
      end
      if (n == 21) idle_a();
      step();
      n++;
    end
    check("sweep_len_a", n, 32);
    idle_a();
    rd_a(5'd3, 5'd3);
    @(negedge clk);
    check("clr_wr_ignored", rd_data_a, 64'h0);
    check("clr_issue_ignored", rd_busy_a, 0);

    // ---- 2. write, read, zero register, bypass ----
    step();
    write_a(5'd7, 32'hDEAD_BEEF);
    rd_a(5'd0, 5'd0);
    step();
    write_a(5'd0, 32'h1234_5678);
    @(negedge clk);
    check("zero_no_bypass", rd_data_a, 64'h0);
    step();
    idle_a();
    rd_a(5'd7, 5'd7);
    @(negedge clk);
    check("rd7_both", rd_data_a, 64'hDEAD_BEEF_DEAD_BEEF);
    rd_a(5'd0, 5'd0);
    #1;
    check("rd0_zero", rd_data_a, 64'h0);
    step();
    write_a(5'd7, 32'hCAFE_F00D);
    rd_a(5'd7, 5'd7);
    @(negedge clk);
    check("bypass7", rd_data_a, 64'hCAFE_F00D_CAFE_F00D);
    step();
    idle_a();
    @(negedge clk);
    check("rd7_after_bypass", rd_data_a, 64'hCAFE_F00D_CAFE_F00D);

    // ---- 3. scoreboard set / clear ----
    step();
    issue_a(5'd9);
    step();
    idle_a();
    step(); step(); step();
    rd_a(5'd9, 5'd8);
    @(negedge clk);
    check("busy9_set", rd_busy_a, 2'b01);
    step();
    write_a(5'd9, 32'h0000_0099);
    @(negedge clk);
    check("busy9_retire_same_cycle", rd_busy_a, 2'b00);
    check("data9_bypass", rd_data_a[31:0], 64'h99);
    step();
    idle_a();
    @(negedge clk);
    check("busy9_after_retire", rd_busy_a, 2'b00);

    // ---- 4. simultaneous set and clear ----
    step();
    issue_a(5'd12);
    write_a(5'd12, 32'h0000_1212);
    rd_a(5'd12, 5'd12);
    @(negedge clk);
    check("busy12_before", rd_busy_a, 2'b00);
    step();
    idle_a();
    @(negedge clk);
    check("busy12_set_wins", rd_busy_a, 2'b11);
    check("data12", rd_data_a, 64'h0000_1212_0000_1212);
    step();
    issue_a(5'd5);
    step();
    issue_a(5'd4);
    write_a(5'd5, 32'h0000_0005);
    step();
    idle_a();
    rd_a(5'd4, 5'd5);
    @(negedge clk);
    check("busy4_set_busy5_clr", rd_busy_a, 2'b01);
    check("data5", rd_data_a[63:32], 64'h5);
    step();
    issue_a(5'd0);
    step();
    idle_a();
    rd_a(5'd0, 5'd0);
    @(negedge clk);
    check("busy0_never", rd_busy_a, 2'b00);

    // ---- 5. reset mid-operation and mid-sweep ----
    step();
    write_a(5'd2, 32'h0000_00AA);
    step();
    idle_a();
    issue_a(5'd2);
    step();
    issue_a(5'd3);
    step();
    idle_a();
    rd_a(5'd2, 5'd3);
    @(negedge clk);
    check("pre_rst_busy23", rd_busy_a, 2'b11);
    check("pre_rst_data2", rd_data_a[31:0], 64'hAA);
    step();
    rst_a = 1'b1;
    @(negedge clk);
    check("run_rst_ready", ready_a, 0);
    step();
    rst_a = 1'b0;
    repeat (10) step();
    rst_a = 1'b1;
    @(negedge clk);
    check("midsweep_rst_ready", ready_a, 0);
    step();
    rst_a = 1'b0;
    wait_ready(1'b0, n);
    check("sweep_len_a2", n, 32);
    for (int a = 0; a < 32; a++) begin
      rd_a(5'(a), 5'(31 - a));
      #1;
      check($sformatf("post_rst_busy_%0d", a), rd_busy_a, 2'b00);
      check($sformatf("post_rst_data_%0d", a), rd_data_a, 64'h0);
    end

    // ---- 6. alternate parameters ----
    step();
    rst_b = 1'b0;
    wait_ready(1'b1, n);
    check("sweep_len_b", n, 16);
    wr_en_b   = 1'b1;
    wr_addr_b = 4'd0;
    wr_data_b = 64'h0123_4567_89AB_CDEF;
    rd_addr_b = '0;
    @(negedge clk);
    check("b_bypass0", rd_data_b[63:0], 64'h0123_4567_89AB_CDEF);
    step();
    wr_en_b = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("b_rd0_port%0d", p), rd_data_b[p*64 +: 64], 64'h0123_4567_89AB_CDEF);
    end
    check("b_busy0_idle", rd_busy_b, 3'b000);
    step();
    issue_en_b = 1'b1;
    issue_rd_b = 4'd0;
    step();
    issue_en_b = 1'b0;
    @(negedge clk);
    check("b_busy0_set", rd_busy_b, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
